// File: rtl/sram_req_scheduler.sv
// sram_req_scheduler: round-robin scheduler sharing one SRAM controller
// between two writers and two readers. Requests pass through a single
// registered issue stage; read data is routed back via an in-order tag FIFO.
module sram_req_scheduler #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 18,
    parameter int DATA_W          = 32,
    localparam int OW             = $clog2(MAX_OUTSTANDING) + 1,
    localparam int DIN_W          = 4 + ADDR_W + DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              w0_valid,
    output logic              w0_ready,
    input  logic [DIN_W-1:0]  w0_din,
    input  logic              w1_valid,
    output logic              w1_ready,
    input  logic [DIN_W-1:0]  w1_din,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    output logic              r0_dout_valid,
    output logic [DATA_W-1:0] r0_dout,
    output logic              r1_dout_valid,
    output logic [DATA_W-1:0] r1_dout,
    output logic              sram_addr_valid,
    input  logic              sram_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_data_in,
    output logic [3:0]        sram_write_mask,
    input  logic [DATA_W-1:0] sram_data_out,
    input  logic              sram_data_out_valid,
    output logic [OW-1:0]     outstanding,
    output logic              protocol_error
);
    localparam int PW = OW - 1;

    // requester index: 0=W0, 1=W1, 2=R0, 3=R1
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [3:0]        mask;
        logic              tag;   // 0 = R0, 1 = R1
    } req_t;

    logic [1:0][3:0]        w_mask;
    logic [1:0][ADDR_W-1:0] w_addr;
    logic [1:0][DATA_W-1:0] w_data;
    logic [3:0]             elig;
    logic [3:0]             grant;
    logic [1:0]             ptr, win, idx;
    logic                   found;
    logic                   free, iss_read, read_ok, push, pop;
    logic [OW:0]            in_use;
    req_t                   nxt;
    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PW-1:0]          wr_ptr, rd_ptr;

    assign w_mask[0] = w0_din[DIN_W-1 -: 4];
    assign w_addr[0] = w0_din[DATA_W +: ADDR_W];
    assign w_data[0] = w0_din[DATA_W-1:0];
    assign w_mask[1] = w1_din[DIN_W-1 -: 4];
    assign w_addr[1] = w1_din[DATA_W +: ADDR_W];
    assign w_data[1] = w1_din[DATA_W-1:0];

    assign free     = !sram_addr_valid || sram_ready;
    assign iss_read = sram_addr_valid && (sram_write_mask == 4'd0);
    assign push     = iss_read && sram_ready;
    assign pop      = sram_data_out_valid && (outstanding != '0);

    // A read held in the issue register is not yet counted in outstanding,
    // so it is added here to keep the tag FIFO from overflowing.
    assign in_use  = {1'b0, outstanding} + {{OW{1'b0}}, iss_read};
    assign read_ok = in_use < (OW+1)'(MAX_OUTSTANDING);

    // A zero-mask write becomes a read, so it is held to the read limit too.
    assign elig[0] = w0_valid && ((w_mask[0] != 4'd0) || read_ok);
    assign elig[1] = w1_valid && ((w_mask[1] != 4'd0) || read_ok);
    assign elig[2] = r0_valid && read_ok;
    assign elig[3] = r1_valid && read_ok;

    // round-robin search starting at ptr; grant only when the issue slot frees
    always_comb begin
        grant = '0;
        win   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found && free && !reset) grant[win] = 1'b1;
    end

    assign w0_ready = grant[0];
    assign w1_ready = grant[1];
    assign r0_ready = grant[2];
    assign r1_ready = grant[3];

    // payload mux for the winning requester; reads carry zero data
    always_comb begin
        nxt = '0;
        case (win)
            2'd0: begin
                nxt.addr = w_addr[0];
                nxt.mask = w_mask[0];
                nxt.data = (w_mask[0] != 4'd0) ? w_data[0] : '0;
            end
            2'd1: begin
                nxt.addr = w_addr[1];
                nxt.mask = w_mask[1];
                nxt.data = (w_mask[1] != 4'd0) ? w_data[1] : '0;
            end
            2'd2: nxt.addr = r0_addr;
            default: begin
                nxt.addr = r1_addr;
                nxt.tag  = 1'b1;
            end
        endcase
    end

    // issue register and round-robin pointer
    logic iss_tag;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sram_addr_valid <= 1'b0;
            sram_addr       <= '0;
            sram_data_in    <= '0;
            sram_write_mask <= '0;
            iss_tag         <= 1'b0;
            ptr             <= 2'd0;
        end else if (free) begin
            sram_addr_valid <= |grant;
            if (|grant) begin
                sram_addr       <= nxt.addr;
                sram_data_in    <= nxt.data;
                sram_write_mask <= nxt.mask;
                iss_tag         <= nxt.tag;
                ptr             <= win + 2'd1;
            end
        end
    end

    // in-order tag FIFO and in-flight read count
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_mem     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= iss_tag;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // registered return path to the tagged reader
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r0_dout_valid <= 1'b0;
            r1_dout_valid <= 1'b0;
            r0_dout       <= '0;
            r1_dout       <= '0;
        end else begin
            r0_dout_valid <= pop && !tag_mem[rd_ptr];
            r1_dout_valid <= pop &&  tag_mem[rd_ptr];
            if (pop && !tag_mem[rd_ptr]) r0_dout <= sram_data_out;
            if (pop &&  tag_mem[rd_ptr]) r1_dout <= sram_data_out;
        end
    end

    // sticky protocol error: unexpected return data or zero-mask write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            protocol_error <= 1'b0;
        end else if ((sram_data_out_valid && outstanding == '0) ||
                     (w0_ready && w_mask[0] == 4'd0) ||
                     (w1_ready && w_mask[1] == 4'd0)) begin
            protocol_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_req_scheduler.sv
// Directed table-driven bench for sram_req_scheduler plus hand sequences
// for reset-in-flight and zero-mask writes.
module tb_sram_req_scheduler;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        w0_valid = 0, w1_valid = 0, r0_valid = 0, r1_valid = 0;
    logic        w0_ready, w1_ready, r0_ready, r1_ready;
    logic [53:0] w0_din, w1_din;
    logic [17:0] r0_addr, r1_addr;
    logic        r0_dout_valid, r1_dout_valid;
    logic [31:0] r0_dout, r1_dout;
    logic        sram_addr_valid;
    logic        sram_ready = 0;
    logic [17:0] sram_addr;
    logic [31:0] sram_data_in;
    logic [3:0]  sram_write_mask;
    logic [31:0] sram_data_out = '0;
    logic        sram_data_out_valid = 0;
    logic [2:0]  outstanding;
    logic        protocol_error;

    int checks = 0;
    int errors = 0;

    sram_req_scheduler dut (
        .clock(clock), .reset(reset),
        .w0_valid(w0_valid), .w0_ready(w0_ready), .w0_din(w0_din),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_din(w1_din),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr),
        .r0_dout_valid(r0_dout_valid), .r0_dout(r0_dout),
        .r1_dout_valid(r1_dout_valid), .r1_dout(r1_dout),
        .sram_addr_valid(sram_addr_valid), .sram_ready(sram_ready),
        .sram_addr(sram_addr), .sram_data_in(sram_data_in),
        .sram_write_mask(sram_write_mask), .sram_data_out(sram_data_out),
        .sram_data_out_valid(sram_data_out_valid),
        .outstanding(outstanding), .protocol_error(protocol_error)
    );

    always #5 clock = ~clock;

    // v / rdy bit order: [0]=W0 [1]=W1 [2]=R0 [3]=R1
    typedef struct {
        logic [3:0]  v;
        logic        rin;
        logic        dov;
        logic [31:0] dat;
        logic [3:0]  e_rdy;
        logic        e_av;
        logic [17:0] e_addr;
        logic [3:0]  e_mask;
        logic [2:0]  e_out;
        logic [1:0]  e_dv;
        logic        e_err;
    } vec_t;

    vec_t tq[$];

    task automatic add(input logic [3:0] v, input logic rin, input logic dov,
                       input logic [31:0] dat, input logic [3:0] e_rdy,
                       input logic e_av, input logic [17:0] e_addr,
                       input logic [3:0] e_mask, input logic [2:0] e_out,
                       input logic [1:0] e_dv, input logic e_err);
        vec_t t;
        t.v = v; t.rin = rin; t.dov = dov; t.dat = dat; t.e_rdy = e_rdy;
        t.e_av = e_av; t.e_addr = e_addr; t.e_mask = e_mask; t.e_out = e_out;
        t.e_dv = e_dv; t.e_err = e_err;
        tq.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // drive one cycle of inputs, sample readys mid-cycle, return after the edge
    task automatic step(input logic [3:0] v, input logic rin, input logic dov,
                        input logic [31:0] dat, output logic [3:0] rdy);
        @(negedge clock);
        {r1_valid, r0_valid, w1_valid, w0_valid} = v;
        sram_ready = rin;
        sram_data_out_valid = dov;
        sram_data_out = dat;
        #1 rdy = {r1_ready, r0_ready, w1_ready, w0_ready};
        @(posedge clock);
        #1;
    endtask

    logic [3:0]  rdy;
    logic [31:0] exp_d0, exp_d1;

    initial begin
        w0_din  = {4'hF, 18'h00010, 32'hDEADBEEF};
        w1_din  = {4'h3, 18'h00020, 32'hCAFEF00D};
        r0_addr = 18'h00030;
        r1_addr = 18'h00031;

        //   v     rin dov dat            rdy  av addr      mask  out dv err
        add(4'h1, 1, 0, 32'h0,          4'h1, 1, 18'h10, 4'hF, 0, 0, 0); // single write
        add(4'h0, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 0, 0, 0);
        add(4'hF, 1, 0, 32'h0,          4'h2, 1, 18'h20, 4'h3, 0, 0, 0); // round robin
        add(4'hF, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 0, 0, 0);
        add(4'hF, 1, 0, 32'h0,          4'h8, 1, 18'h31, 4'h0, 1, 0, 0);
        add(4'hF, 1, 0, 32'h0,          4'h1, 1, 18'h10, 4'hF, 2, 0, 0);
        add(4'hF, 1, 1, 32'hAAAA0001,   4'h2, 1, 18'h20, 4'h3, 1, 1, 0);
        add(4'h0, 1, 1, 32'hBBBB0002,   4'h0, 0, 18'h0,  4'h0, 0, 2, 0);
        add(4'h0, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 0, 0, 0);
        add(4'h2, 0, 0, 32'h0,          4'h2, 1, 18'h20, 4'h3, 0, 0, 0); // backpressure
        for (int i = 0; i < 5; i++)
            add(4'hF, 0, 0, 32'h0,      4'h0, 1, 18'h20, 4'h3, 0, 0, 0);
        add(4'hF, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 0, 0, 0);
        add(4'h0, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 1, 0, 0);
        add(4'h0, 1, 1, 32'hCCCC0003,   4'h0, 0, 18'h0,  4'h0, 0, 1, 0);
        add(4'h4, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 0, 0, 0); // limit
        add(4'h4, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 1, 0, 0);
        add(4'h4, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 2, 0, 0);
        add(4'h4, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 3, 0, 0);
        add(4'h4, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 4, 0, 0);
        add(4'h6, 1, 0, 32'h0,          4'h2, 1, 18'h20, 4'h3, 4, 0, 0);
        add(4'h4, 1, 1, 32'hDDDD0004,   4'h0, 0, 18'h0,  4'h0, 3, 1, 0);
        add(4'h4, 1, 0, 32'h0,          4'h4, 1, 18'h30, 4'h0, 3, 0, 0);
        add(4'h0, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 4, 0, 0);
        add(4'h4, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 4, 0, 0);
        add(4'h0, 1, 1, 32'hEEEE0001,   4'h0, 0, 18'h0,  4'h0, 3, 1, 0);
        add(4'h0, 1, 1, 32'hEEEE0002,   4'h0, 0, 18'h0,  4'h0, 2, 1, 0);
        add(4'h0, 1, 1, 32'hEEEE0003,   4'h0, 0, 18'h0,  4'h0, 1, 1, 0);
        add(4'h0, 1, 1, 32'hEEEE0004,   4'h0, 0, 18'h0,  4'h0, 0, 1, 0);
        add(4'h0, 1, 1, 32'hFFFF0000,   4'h0, 0, 18'h0,  4'h0, 0, 0, 1); // empty return
        add(4'h0, 1, 0, 32'h0,          4'h0, 0, 18'h0,  4'h0, 0, 0, 1);

        // reset state, with a writer already requesting
        w0_valid = 1'b1;
        sram_ready = 1'b1;
        #2;
        chk("rst_w0_ready", 64'(w0_ready), 64'd0);
        chk("rst_av", 64'(sram_addr_valid), 64'd0);
        chk("rst_out", 64'(outstanding), 64'd0);
        chk("rst_err", 64'(protocol_error), 64'd0);
        chk("rst_payload", {8'h0, sram_addr, sram_data_in, sram_write_mask, 2'b0}, 64'd0);
        chk("rst_dout", {r0_dout, r1_dout}, 64'd0);
        @(negedge clock);
        @(negedge clock);
        w0_valid = 1'b0;
        reset = 1'b0;

        exp_d0 = '0;
        exp_d1 = '0;
        foreach (tq[i]) begin
            step(tq[i].v, tq[i].rin, tq[i].dov, tq[i].dat, rdy);
            if (tq[i].e_dv[0]) exp_d0 = tq[i].dat;
            if (tq[i].e_dv[1]) exp_d1 = tq[i].dat;
            chk($sformatf("v%0d_rdy", i), 64'(rdy), 64'(tq[i].e_rdy));
            chk($sformatf("v%0d_av", i), 64'(sram_addr_valid), 64'(tq[i].e_av));
            if (tq[i].e_av) begin
                chk($sformatf("v%0d_addr", i), 64'(sram_addr), 64'(tq[i].e_addr));
                chk($sformatf("v%0d_mask", i), 64'(sram_write_mask), 64'(tq[i].e_mask));
                chk($sformatf("v%0d_wdata", i), 64'(sram_data_in),
                    (tq[i].e_mask == 4'h0) ? 64'd0 :
                    (tq[i].e_addr == 18'h10) ? 64'hDEADBEEF : 64'hCAFEF00D);
            end
            chk($sformatf("v%0d_out", i), 64'(outstanding), 64'(tq[i].e_out));
            chk($sformatf("v%0d_dv", i), 64'({r1_dout_valid, r0_dout_valid}), 64'(tq[i].e_dv));
            chk($sformatf("v%0d_d0", i), 64'(r0_dout), 64'(exp_d0));
            chk($sformatf("v%0d_d1", i), 64'(r1_dout), 64'(exp_d1));
            chk($sformatf("v%0d_err", i), 64'(protocol_error), 64'(tq[i].e_err));
        end

        // reset with two reads in flight
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("rst2_err", 64'(protocol_error), 64'd0);
        step(4'h4, 1, 0, 0, rdy);
        chk("mf_rdy0", 64'(rdy), 64'h4);
        step(4'h4, 1, 0, 0, rdy);
        chk("mf_rdy1", 64'(rdy), 64'h4);
        step(4'h0, 1, 0, 0, rdy);
        chk("mf_out2", 64'(outstanding), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("mf_out_rst", 64'(outstanding), 64'd0);
        chk("mf_av_rst", 64'(sram_addr_valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step(4'hF, 1, 0, 0, rdy);
        chk("mf_ptr_w0", 64'(rdy), 64'h1);
        chk("mf_w0_addr", 64'(sram_addr), 64'h10);
        step(4'h0, 1, 1, 32'h11112222, rdy);
        chk("mf_late_err", 64'(protocol_error), 64'd1);
        chk("mf_late_dv", 64'({r1_dout_valid, r0_dout_valid}), 64'd0);
        step(4'h0, 1, 0, 0, rdy);
        chk("mf_err_hold", 64'(protocol_error), 64'd1);

        // zero-mask write: flagged, issued as an R0 read
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        w0_din = {4'h0, 18'h00055, 32'h12345678};
        step(4'h1, 1, 0, 0, rdy);
        chk("zm_rdy", 64'(rdy), 64'h1);
        chk("zm_mask", 64'(sram_write_mask), 64'h0);
        chk("zm_addr", 64'(sram_addr), 64'h55);
        chk("zm_data", 64'(sram_data_in), 64'h0);
        chk("zm_err", 64'(protocol_error), 64'd1);
        step(4'h0, 1, 0, 0, rdy);
        chk("zm_out", 64'(outstanding), 64'd1);
        step(4'h0, 1, 1, 32'h00000077, rdy);
        chk("zm_dv", 64'({r1_dout_valid, r0_dout_valid}), 64'h1);
        chk("zm_d0", 64'(r0_dout), 64'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sram_req_scheduler.md
Name: sram_req_scheduler

Overview:
- Single-clock core scheduler that shares the SRAM controller between two write requesters (W0: image buffer writer, W1: overlay writer) and two read requesters (R0: image buffer reader, R1: spare).
- Sits after the per-port clock-domain-crossing FIFOs and drives the SRAM controller request/response interface in the sram_clock domain.
- Round-robin arbitration with a registered issue stage. Read data is routed back to the reader that issued the request through an in-order tag FIFO.

Parameters:
- MAX_OUTSTANDING, 4: maximum reads issued but not yet returned (power of 2, 2..16).
- ADDR_W, 18: SRAM word address width.
- DATA_W, 32: SRAM data width.

Ports:
- clock  in  1  sram_clock domain clock.
- reset  in  1  asynchronous, active-high reset.
- w0_valid / w1_valid  in  1  write request valid.
- w0_ready / w1_ready  out  1  write request accepted this cycle.
- w0_din / w1_din  in  54  {mask[3:0], addr[17:0], data[31:0]}; mask must be nonzero.
- r0_valid / r1_valid  in  1  read request valid.
- r0_ready / r1_ready  out  1  read request accepted this cycle.
- r0_addr / r1_addr  in  18  read address.
- r0_dout_valid / r1_dout_valid  out  1  one-cycle return data strobe; no backpressure.
- r0_dout / r1_dout  out  32  returned read data.
- sram_addr_valid  out  1  request to the SRAM controller.
- sram_ready  in  1  SRAM controller accepts the request.
- sram_addr  out  18  request address.
- sram_data_in  out  32  write data; 0 for reads.
- sram_write_mask  out  4  byte-write mask; 4'b0000 denotes a read.
- sram_data_out  in  32  read data from the controller.
- sram_data_out_valid  in  1  read data strobe; reads return in issue order.
- outstanding  out  log2(MAX_OUTSTANDING)+1  current reads in flight (debug).
- protocol_error  out  1  sticky error flag.

Behaviour:
- Reset (async): all ready signals, sram_addr_valid, all dout_valid and protocol_error are 0. sram_addr, sram_data_in, sram_write_mask, both dout buses and outstanding are 0. Tag FIFO is emptied. Round-robin pointer is W0.
- Reset asserted mid-operation discards every in-flight tag; any data returned after reset is released is flagged as an error (see below).
- Issue register: holds one request. It is "free" when empty, or when sram_addr_valid && sram_ready in the current cycle.
- Arbitration runs only when the issue register is free.
  - Eligible requesters are those asserting valid. A read is eligible only if (outstanding + reads pending in the issue register) < MAX_OUTSTANDING.
  - Search order starts at the pointer and proceeds W0 -> W1 -> R0 -> R1 -> W0.
  - The first eligible requester gets its ready asserted combinationally in the same cycle.
  - On the next edge the issue register loads the request and sram_addr_valid = 1.
  - The pointer moves to the requester after the winner.
  - At most one ready is high per cycle.
- Latency: request handshake to sram_addr_valid = 1 cycle. Back-to-back issue at 1 request per cycle while sram_ready = 1.
- Output stability: sram_addr_valid and the payload stay constant until sram_ready is sampled high. There is no retraction.
- Tag FIFO:
  - Depth MAX_OUTSTANDING, 1-bit tag (0 = R0, 1 = R1).
  - Push on a read handshake with the SRAM (sram_addr_valid && sram_ready && mask == 0).
  - Pop on sram_data_out_valid.
  - outstanding increments on push and decrements on pop. A simultaneous push and pop leaves it unchanged.
- Return path (registered, 1 cycle after sram_data_out_valid): the tagged reader's dout_valid = 1 and its dout = sram_data_out. The other reader's dout_valid stays 0. dout holds its last value otherwise.
- protocol_error sets and holds until reset on either condition:
  - sram_data_out_valid while the tag FIFO is empty. The data is dropped and no dout_valid is raised.
  - A write request presented with mask == 0. It is still issued, as a read, with tag R0.
- Full condition: with outstanding == MAX_OUTSTANDING, writes continue to be granted and reads stall.
- No starvation: any continuously valid, eligible requester is granted within 4 arbitration opportunities.

Test Plan:
- Single write: w0_valid with {4'hF, 18'h00010, 32'hDEADBEEF}, sram_ready = 1 -> w0_ready high 1 cycle. Next cycle sram_addr_valid = 1, addr = 0x10, data = DEADBEEF, mask = F. Outstanding stays 0.
- Round-robin: all four valid continuously, sram_ready = 1 -> grant sequence W0, W1, R0, R1, W0, ... one grant per cycle. Reads return in order, with r0_dout_valid/r1_dout_valid matching the issuer.
- Backpressure: sram_ready = 0 for 5 cycles with a request loaded -> sram_addr_valid and payload stable, all readys 0. They resume the cycle sram_ready rises.
- Outstanding limit: MAX_OUTSTANDING = 4, r0_valid held high, no data returned -> exactly 4 reads issued, then r0_ready = 0. A concurrent w1 request is still granted. One return brings outstanding to 3 and allows one more read.
- Error: pulse sram_data_out_valid with outstanding = 0 -> protocol_error = 1 and no dout_valid. It remains 1 until reset.
- Reset mid-flight: 2 reads outstanding, assert reset -> outstanding = 0, sram_addr_valid = 0, pointer = W0. A later sram_data_out_valid sets protocol_error.
